// File: rtl/pp_pkg.sv
// Shared definitions for the periplex stream decoder: default geometry,
// header field offsets and the decoder state encoding.
package pp_pkg;

  localparam int unsigned PP_PKT_W       = 48;
  localparam int unsigned PP_SEL_W       = 7;
  localparam int unsigned PP_LEN_W       = 7;
  localparam int unsigned PP_HDR_BYTES   = 4;
  localparam int unsigned PP_FRAME_BYTES = 6;
  localparam int unsigned PP_NUM_GRP     = 4;
  localparam logic [PP_NUM_GRP*PP_SEL_W-1:0] PP_GRP_LIMITS = {7'd8, 7'd6, 7'd4, 7'd2};

  // Header fields pack downward from the MSB: cfg, sel, parallel, len.
  function automatic int unsigned sel_lsb(input int unsigned pkt_w, input int unsigned sel_w);
    return pkt_w - 1 - sel_w;
  endfunction

  function automatic int unsigned par_bit(input int unsigned pkt_w, input int unsigned sel_w);
    return pkt_w - 2 - sel_w;
  endfunction

  function automatic int unsigned len_lsb(input int unsigned pkt_w, input int unsigned sel_w,
                                          input int unsigned len_w);
    return pkt_w - 2 - sel_w - len_w;
  endfunction

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    HDR_WAIT  = 3'd1,
    HDR_OUT   = 3'd2,
    BODY_REQ  = 3'd3,
    BODY_WAIT = 3'd4,
    BODY_OUT  = 3'd5
  } state_t;

endpackage

// File: rtl/pp_grp_sel.sv
// Maps a slave select onto a one-hot peripheral group enable using ascending
// exclusive upper bounds; selects past the last bound raise sel_err.
module pp_grp_sel
  import pp_pkg::*;
#(
  parameter int unsigned NUM_GRP = PP_NUM_GRP,
  parameter int unsigned SEL_W   = PP_SEL_W,
  parameter logic [NUM_GRP*SEL_W-1:0] GRP_LIMITS = PP_GRP_LIMITS
) (
  input  logic [SEL_W-1:0]   sel,
  output logic [NUM_GRP-1:0] grp_en,
  output logic               sel_err
);

  logic [SEL_W-1:0] lo;
  logic [SEL_W-1:0] hi;

  always_comb begin
    grp_en = '0;
    lo     = '0;
    hi     = '0;
    for (int unsigned g = 0; g < NUM_GRP; g++) begin
      hi = GRP_LIMITS[g*SEL_W +: SEL_W];
      if (sel >= lo && sel < hi) grp_en[g] = 1'b1;
      lo = hi;
    end
    sel_err = (sel >= GRP_LIMITS[(NUM_GRP-1)*SEL_W +: SEL_W]);
  end

endmodule

// File: rtl/pp_stream_decoder.sv
// Pops header/continuation frames from the RAH FIFO, decodes the header and
// presents each frame on a valid/ready port with group enable and sel_err.
module pp_stream_decoder
  import pp_pkg::*;
#(
  parameter int unsigned PKT_W       = PP_PKT_W,
  parameter int unsigned SEL_W       = PP_SEL_W,
  parameter int unsigned LEN_W       = PP_LEN_W,
  parameter int unsigned HDR_BYTES   = PP_HDR_BYTES,
  parameter int unsigned FRAME_BYTES = PP_FRAME_BYTES,
  parameter int unsigned NUM_GRP     = PP_NUM_GRP,
  parameter logic [NUM_GRP*SEL_W-1:0] GRP_LIMITS = PP_GRP_LIMITS
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PKT_W-1:0]   fifo_rd_data,
  input  logic               fifo_empty,
  output logic               fifo_rd_en,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_cfg,
  output logic               out_parallel,
  output logic [SEL_W-1:0]   out_slv_sel,
  output logic [LEN_W-1:0]   out_str_len,
  output logic [PKT_W-1:0]   out_value,
  output logic               out_first,
  output logic               out_last,
  output logic [NUM_GRP-1:0] grp_en,
  output logic               sel_err,
  output logic               busy
);

  localparam int unsigned SEL_LSB = sel_lsb(PKT_W, SEL_W);
  localparam int unsigned PAR_BIT = par_bit(PKT_W, SEL_W);
  localparam int unsigned LEN_LSB = len_lsb(PKT_W, SEL_W, LEN_W);
  localparam logic [LEN_W-1:0] HDR_LEN   = LEN_W'(HDR_BYTES);
  localparam logic [LEN_W-1:0] FRAME_LEN = LEN_W'(FRAME_BYTES);

  state_t             state;
  logic [LEN_W-1:0]   rem;
  logic [NUM_GRP-1:0] grp_en_r;
  logic               sel_err_r;

  logic               hdr_cfg;
  logic               hdr_par;
  logic [SEL_W-1:0]   hdr_sel;
  logic [LEN_W-1:0]   hdr_len;
  logic [NUM_GRP-1:0] hdr_grp;
  logic               hdr_err;

  assign hdr_cfg = fifo_rd_data[PKT_W-1];
  assign hdr_sel = fifo_rd_data[SEL_LSB +: SEL_W];
  assign hdr_par = fifo_rd_data[PAR_BIT];
  assign hdr_len = fifo_rd_data[LEN_LSB +: LEN_W];

  pp_grp_sel #(
    .NUM_GRP    (NUM_GRP),
    .SEL_W      (SEL_W),
    .GRP_LIMITS (GRP_LIMITS)
  ) u_grp_sel (
    .sel     (hdr_sel),
    .grp_en  (hdr_grp),
    .sel_err (hdr_err)
  );

  assign fifo_rd_en = rst_n && (state == IDLE || state == BODY_REQ) && !fifo_empty && !flush;
  assign busy       = (state != IDLE);
  assign grp_en     = grp_en_r & {NUM_GRP{out_valid}};
  assign sel_err    = sel_err_r & out_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      rem          <= '0;
      grp_en_r     <= '0;
      sel_err_r    <= 1'b0;
      out_valid    <= 1'b0;
      out_cfg      <= 1'b0;
      out_parallel <= 1'b0;
      out_slv_sel  <= '0;
      out_str_len  <= '0;
      out_value    <= '0;
      out_first    <= 1'b0;
      out_last     <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (fifo_rd_en) state <= HDR_WAIT;
        HDR_WAIT: begin
          out_cfg      <= hdr_cfg;
          out_parallel <= hdr_par;
          out_slv_sel  <= hdr_sel;
          out_str_len  <= hdr_len;
          out_value    <= PKT_W'(fifo_rd_data[HDR_BYTES*8-1:0]);
          out_first    <= 1'b1;
          out_last     <= hdr_par || (hdr_len <= HDR_LEN);
          grp_en_r     <= hdr_grp;
          sel_err_r    <= hdr_err;
          out_valid    <= 1'b1;
          state        <= HDR_OUT;
        end
        HDR_OUT: if (out_ready) begin
          out_valid <= 1'b0;
          if (out_last) begin
            state <= IDLE;
          end else begin
            rem   <= out_str_len - HDR_LEN;
            state <= BODY_REQ;
          end
        end
        BODY_REQ: if (fifo_rd_en) state <= BODY_WAIT;
        BODY_WAIT: begin
          out_value   <= fifo_rd_data;
          out_str_len <= rem;
          out_first   <= 1'b0;
          out_last    <= (rem <= FRAME_LEN);
          out_valid   <= 1'b1;
          state       <= BODY_OUT;
        end
        BODY_OUT: if (out_ready) begin
          out_valid <= 1'b0;
          if (out_last) begin
            state <= IDLE;
          end else begin
            rem   <= rem - FRAME_LEN;
            state <= BODY_REQ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pp_stream_decoder.sv
// Directed bench for pp_stream_decoder: a small FIFO model feeds hand-built
// headers/frames and every output field is compared with worked-out values.
module tb_pp_stream_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [47:0] fifo_rd_data = '0;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_cfg;
  logic        out_parallel;
  logic [6:0]  out_slv_sel;
  logic [6:0]  out_str_len;
  logic [47:0] out_value;
  logic        out_first;
  logic        out_last;
  logic [3:0]  grp_en;
  logic        sel_err;
  logic        busy;

  int unsigned total = 0;
  int unsigned bad = 0;

  logic [47:0] mem [0:63];
  int unsigned wr_ptr = 0;
  int unsigned rd_ptr = 0;
  int unsigned rd_cnt = 0;

  always #5 clk = ~clk;

  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_rd_data <= mem[rd_ptr % 64];
      rd_ptr       <= rd_ptr + 1;
      rd_cnt       <= rd_cnt + 1;
    end
  end

  pp_stream_decoder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fifo_rd_data (fifo_rd_data),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_cfg      (out_cfg),
    .out_parallel (out_parallel),
    .out_slv_sel  (out_slv_sel),
    .out_str_len  (out_str_len),
    .out_value    (out_value),
    .out_first    (out_first),
    .out_last     (out_last),
    .grp_en       (grp_en),
    .sel_err      (sel_err),
    .busy         (busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [47:0] d);
    mem[wr_ptr % 64] = d;
    wr_ptr++;
  endtask

  task automatic drop_fifo();
    wr_ptr = rd_ptr;
  endtask

  task automatic wait_valid(input string tag, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 40);
    if (!out_valid) chk({tag, ".timeout"}, 64'd0, 64'd1);
  endtask

  task automatic chk_frame(input string t, input logic cfg, input logic par,
                           input logic [6:0] sel, input logic [3:0] grp, input logic err,
                           input logic first, input logic last, input logic [6:0] len,
                           input logic [47:0] val);
    chk({t, ".valid"}, out_valid, 1);
    chk({t, ".cfg"},   out_cfg, cfg);
    chk({t, ".par"},   out_parallel, par);
    chk({t, ".sel"},   out_slv_sel, sel);
    chk({t, ".grp"},   grp_en, grp);
    chk({t, ".err"},   sel_err, err);
    chk({t, ".first"}, out_first, first);
    chk({t, ".last"},  out_last, last);
    chk({t, ".len"},   out_str_len, len);
    chk({t, ".value"}, out_value, val);
  endtask

  task automatic settle_idle(input string t);
    int n = 0;
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({t, ".idle"}, busy, 0);
    chk({t, ".vdrop"}, out_valid, 0);
  endtask

  initial begin
    int n;
    int unsigned rd0;
    logic [47:0] v_hold;
    logic [6:0]  l_hold;

    // Reset state, with a header already waiting in the FIFO.
    push(48'h8384_DEADBEEF);
    #3;
    chk("rst.valid", out_valid, 0);
    chk("rst.rden",  fifo_rd_en, 0);
    chk("rst.busy",  busy, 0);
    chk("rst.grp",   grp_en, 0);
    chk("rst.err",   sel_err, 0);
    chk("rst.value", out_value, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: parallel header, sel=3 -> group 1, out_valid two cycles after pop.
    rd0 = rd_cnt;
    wait_valid("t1", n);
    chk("t1.latency", n, 2);
    chk_frame("t1", 1, 1, 7'd3, 4'b0010, 0, 1, 1, 7'd4, 48'h0000_DEADBEEF);
    @(negedge clk);
    chk("t1.pulse", out_valid, 0);
    settle_idle("t1");
    chk("t1.pops", rd_cnt - rd0, 1);

    // 2: serial packet sel=5 len=16 -> 16/12/6.
    rd0 = rd_cnt;
    push(48'h0510_11223344);
    push(48'hA1A2A3A4A5A6);
    push(48'hB1B2B3B4B5B6);
    wait_valid("t2f1", n);
    chk_frame("t2f1", 0, 0, 7'd5, 4'b0100, 0, 1, 0, 7'd16, 48'h0000_11223344);
    wait_valid("t2f2", n);
    chk_frame("t2f2", 0, 0, 7'd5, 4'b0100, 0, 0, 0, 7'd12, 48'hA1A2A3A4A5A6);
    wait_valid("t2f3", n);
    chk_frame("t2f3", 0, 0, 7'd5, 4'b0100, 0, 0, 1, 7'd6, 48'hB1B2B3B4B5B6);
    settle_idle("t2");
    chk("t2.pops", rd_cnt - rd0, 3);

    // 3: same packet, frame 2 stalled for 5 cycles.
    rd0 = rd_cnt;
    push(48'h0510_11223344);
    push(48'hA1A2A3A4A5A6);
    push(48'hB1B2B3B4B5B6);
    wait_valid("t3f1", n);
    chk_frame("t3f1", 0, 0, 7'd5, 4'b0100, 0, 1, 0, 7'd16, 48'h0000_11223344);
    @(negedge clk);
    out_ready = 1'b0;
    wait_valid("t3f2", n);
    chk_frame("t3f2", 0, 0, 7'd5, 4'b0100, 0, 0, 0, 7'd12, 48'hA1A2A3A4A5A6);
    v_hold = out_value;
    l_hold = out_str_len;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3.hold_valid", out_valid, 1);
      chk("t3.hold_value", out_value, v_hold);
      chk("t3.hold_len",   out_str_len, l_hold);
      chk("t3.hold_grp",   grp_en, 4'b0100);
      chk("t3.hold_rden",  fifo_rd_en, 0);
    end
    chk("t3.stall_pops", rd_cnt - rd0, 2);
    out_ready = 1'b1;
    wait_valid("t3f3", n);
    chk_frame("t3f3", 0, 0, 7'd5, 4'b0100, 0, 0, 1, 7'd6, 48'hB1B2B3B4B5B6);
    settle_idle("t3");
    chk("t3.pops", rd_cnt - rd0, 3);

    // 4: out-of-range selects; sel=8 is the first value past the last limit.
    push(48'h0984_CAFEF00D);
    wait_valid("t4a", n);
    chk_frame("t4a", 0, 1, 7'd9, 4'b0000, 1, 1, 1, 7'd4, 48'h0000_CAFEF00D);
    settle_idle("t4a");
    push(48'h0881_00000011);
    wait_valid("t4b", n);
    chk_frame("t4b", 0, 1, 7'd8, 4'b0000, 1, 1, 1, 7'd1, 48'h0000_00000011);
    settle_idle("t4b");
    push(48'h090A_01020304);
    push(48'hC1C2C3C4C5C6);
    wait_valid("t4f1", n);
    chk_frame("t4f1", 0, 0, 7'd9, 4'b0000, 1, 1, 0, 7'd10, 48'h0000_01020304);
    wait_valid("t4f2", n);
    chk_frame("t4f2", 0, 0, 7'd9, 4'b0000, 1, 0, 1, 7'd6, 48'hC1C2C3C4C5C6);
    settle_idle("t4");
    chk("t4.err_idle", sel_err, 0);

    // 5: starvation in BODY_REQ, then serial len=4 single frame.
    push(48'h010A_55667788);
    wait_valid("t5f1", n);
    chk_frame("t5f1", 0, 0, 7'd1, 4'b0001, 0, 1, 0, 7'd10, 48'h0000_55667788);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i % 3 == 2) begin
        chk("t5.starve_valid", out_valid, 0);
        chk("t5.starve_busy",  busy, 1);
        chk("t5.starve_grp",   grp_en, 0);
      end
    end
    push(48'hD1D2D3D4D5D6);
    wait_valid("t5f2", n);
    chk_frame("t5f2", 0, 0, 7'd1, 4'b0001, 0, 0, 1, 7'd6, 48'hD1D2D3D4D5D6);
    settle_idle("t5");
    rd0 = rd_cnt;
    push(48'h0204_12345678);
    wait_valid("t5s", n);
    chk_frame("t5s", 0, 0, 7'd2, 4'b0010, 0, 1, 1, 7'd4, 48'h0000_12345678);
    settle_idle("t5s");
    chk("t5s.pops", rd_cnt - rd0, 1);

    // 6a: flush while the second frame is in flight (BODY_WAIT).
    rd0 = rd_cnt;
    push(48'h0510_11223344);
    push(48'hA1A2A3A4A5A6);
    push(48'hB1B2B3B4B5B6);
    wait_valid("t6f1", n);
    chk_frame("t6f1", 0, 0, 7'd5, 4'b0100, 0, 1, 0, 7'd16, 48'h0000_11223344);
    @(negedge clk);
    @(negedge clk);
    chk("t6.in_wait_pops", rd_cnt - rd0, 2);
    chk("t6.in_wait_busy", busy, 1);
    flush = 1'b1;
    drop_fifo();
    @(negedge clk);
    chk("t6.flush_valid", out_valid, 0);
    chk("t6.flush_grp",   grp_en, 0);
    chk("t6.flush_busy",  busy, 0);
    chk("t6.flush_last",  out_last, 0);
    flush = 1'b0;
    push(48'h8384_DEADBEEF);
    wait_valid("t6h", n);
    chk_frame("t6h", 1, 1, 7'd3, 4'b0010, 0, 1, 1, 7'd4, 48'h0000_DEADBEEF);
    settle_idle("t6h");

    // 6b: reset while holding frame 2 in BODY_OUT.
    push(48'h0510_11223344);
    push(48'hA1A2A3A4A5A6);
    push(48'hB1B2B3B4B5B6);
    wait_valid("t6bf1", n);
    @(negedge clk);
    out_ready = 1'b0;
    wait_valid("t6bf2", n);
    chk("t6b.held", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("t6b.rst_valid", out_valid, 0);
    chk("t6b.rst_grp",   grp_en, 0);
    chk("t6b.rst_busy",  busy, 0);
    chk("t6b.rst_rden",  fifo_rd_en, 0);
    drop_fifo();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    push(48'h8782_0000BEEF);
    wait_valid("t6bh", n);
    chk_frame("t6bh", 1, 1, 7'd7, 4'b1000, 0, 1, 1, 7'd2, 48'h0000_0000BEEF);
    settle_idle("t6bh");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
